rv32_alu: RTL and testbench



---
 rtl/rv32_pkg.sv | 18 +
 rtl/alu_shifter.sv | 28 ++
 rtl/rv32_alu.sv | 74 +++++++
 tb/tb_rv32_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: datapath width and
// funct3 operation encodings.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SR      = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by SLL, SRL and SRA.
module alu_shifter
  import rv32_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] data,
  input  logic [4:0]   amt,
  input  logic         right,
  input  logic         arith,
  output logic [W-1:0] result
);

  // Select shift direction and fill; arith only matters for right shifts
  always_comb begin
    result = {W{1'b0}};
    if (right) begin
      if (arith) begin
        result = $signed(data) >>> amt;
      end else begin
        result = data >> amt;
      end
    end else begin
      result = data << amt;
    end
  end

endmodule

// File: rtl/rv32_alu.sv
// Registered RV32I R-type ALU: one shared adder/subtractor, a barrel shifter
// and a result mux feeding the rd/z register with one cycle of latency.
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  output logic [XLEN-1:0] rd,
  output logic            z
);

  funct3_e         op_s;
  logic            sub_s;
  logic [XLEN-1:0] addend_s;
  logic [XLEN:0]   sum_s;
  logic            lt_s;
  logic            ltu_s;
  logic [XLEN-1:0] shift_s;
  logic [XLEN-1:0] res_s;

  assign op_s = funct3_e'(funct3);

  // Compares reuse the adder in subtract mode
  assign sub_s    = ((op_s == F3_ADD_SUB) && funct7) || (op_s == F3_SLT) || (op_s == F3_SLTU);
  assign addend_s = sub_s ? ~rs2 : rs2;
  assign sum_s    = {1'b0, rs1} + {1'b0, addend_s} + {{XLEN{1'b0}}, sub_s};

  // No borrow out of rs1 - rs2 means rs1 >= rs2 unsigned
  assign ltu_s = ~sum_s[XLEN];
  // Differing signs decide directly; otherwise the difference cannot overflow
  assign lt_s  = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs1[XLEN-1] : sum_s[XLEN-1];

  alu_shifter #(.W(XLEN)) u_shifter (
    .data   (rs1),
    .amt    (rs2[4:0]),
    .right  (op_s == F3_SR),
    .arith  (funct7),
    .result (shift_s)
  );

  // Result mux selecting the operation output
  always_comb begin
    res_s = {XLEN{1'b0}};
    case (op_s)
      F3_ADD_SUB: res_s = sum_s[XLEN-1:0];
      F3_SLL:     res_s = shift_s;
      F3_SLT:     res_s = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU:    res_s = {{(XLEN-1){1'b0}}, ltu_s};
      F3_XOR:     res_s = rs1 ^ rs2;
      F3_SR:      res_s = shift_s;
      F3_OR:      res_s = rs1 | rs2;
      F3_AND:     res_s = rs1 & rs2;
      default:    res_s = {XLEN{1'b0}};
    endcase
  end

  // Output register; z is derived from the same next-state value as rd
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd <= {XLEN{1'b0}};
      z  <= 1'b1;
    end else begin
      rd <= res_s;
      z  <= (res_s == {XLEN{1'b0}});
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed cases with fixed expectations
// followed by back-to-back random vectors against a behavioural model.
module tb_rv32_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] rd;
  logic        z;

  int total;
  int bad;

  rv32_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .z      (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic f7);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0:    return f7 ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7 ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic f7);
    rs1 = a;
    rs2 = b;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Apply one op, wait one edge, compare against a constant expectation
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f7, input logic [31:0] exp);
    drive(a, b, f3, f7);
    @(posedge clk);
    #1;
    check(tag, rd, exp);
    check({tag, "_z"}, {31'd0, z}, {31'd0, exp == 32'd0});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] exp;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(32'd5, 32'd7, 3'd0, 1'b0);

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rd", rd, 32'd0);
    check("reset_z", {31'd0, z}, 32'd1);

    rst_n = 1'b1;
    directed("release_add", 32'd5, 32'd7, 3'd0, 1'b0, 32'd12);

    directed("add_20_30",   32'd20, 32'd30, 3'd0, 1'b0, 32'd50);
    directed("sub_8_3",     32'd8, 32'd3, 3'd0, 1'b1, 32'd5);
    directed("sub_20_20",   32'd20, 32'd20, 3'd0, 1'b1, 32'd0);
    directed("sub_0_1",     32'd0, 32'd1, 3'd0, 1'b1, 32'hFFFF_FFFF);
    directed("add_wrap",    32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0, 32'd0);

    directed("slt_8_3",     32'd8, 32'd3, 3'd2, 1'b0, 32'd0);
    directed("slt_m1_1",    32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 32'd1);
    directed("sltu_max_1",  32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0, 32'd0);
    directed("sltu_3_8",    32'd3, 32'd8, 3'd3, 1'b0, 32'd1);
    directed("slt_f7",      32'h8000_0000, 32'h7FFF_FFFF, 3'd2, 1'b1, 32'd1);
    directed("sltu_f7",     32'h8000_0000, 32'h7FFF_FFFF, 3'd3, 1'b1, 32'd0);

    directed("sll_8_3",     32'd8, 32'd3, 3'd1, 1'b0, 32'd64);
    directed("srl_8_3",     32'd8, 32'd3, 3'd5, 1'b0, 32'd1);
    directed("sra_8_3",     32'd8, 32'd3, 3'd5, 1'b1, 32'd1);
    directed("sra_neg",     32'h8000_0000, 32'd4, 3'd5, 1'b1, 32'hF800_0000);
    directed("srl_neg",     32'h8000_0000, 32'd4, 3'd5, 1'b0, 32'h0800_0000);
    directed("sll_amt_hi",  32'd1, 32'h0000_0021, 3'd1, 1'b0, 32'd2);
    directed("sll_f7",      32'd1, 32'd31, 3'd1, 1'b1, 32'h8000_0000);
    directed("sra_zero",    32'h8000_0001, 32'hFFFF_FFE0, 3'd5, 1'b1, 32'h8000_0001);

    for (int k = 0; k < 2; k++) begin
      f7 = (k == 1);
      directed("xor_20_30", 32'd20, 32'd30, 3'd4, f7, 32'd10);
      directed("or_20_30",  32'd20, 32'd30, 3'd6, f7, 32'd30);
      directed("and_20_30", 32'd20, 32'd30, 3'd7, f7, 32'd20);
    end

    // Reset in mid-stream discards the pending result
    drive(32'd100, 32'd1, 3'd0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_rd", rd, 32'd0);
    check("midreset_z", {31'd0, z}, 32'd1);
    rst_n = 1'b1;
    directed("after_midreset", 32'd100, 32'd1, 3'd0, 1'b0, 32'd101);

    // Back-to-back random vectors, new op every cycle
    for (int i = 0; i < 100; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = {27'd0, b[4:0]};
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      exp = model(a, b, f3, f7);
      drive(a, b, f3, f7);
      @(posedge clk);
      #1;
      check("rand_rd", rd, exp);
      check("rand_z", {31'd0, z}, {31'd0, exp == 32'd0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
